csram_sync: RTL and testbench

- Parametrised, clocked successor to the CPU's combinational program/data SRAM model.
- Provides a single-port req/ack memory with configurable wait states and sequential-write loader port; program images are streamed in at run time rather than compiled in.
- Sits between the LC-3 core's memory interface and an external program loader (UART/SPI boot logic).

---
 rtl/csram_sync_pkg.sv | 18 +
 rtl/csram_sync_array.sv | 35 +++
 rtl/csram_sync.sv | 182 ++++++++++++++++++
 tb/tb_csram_sync.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/csram_sync_pkg.sv
// Shared types and constants for the clocked program/data SRAM.
//   state_e          : access FSM states (IDLE / WAIT / ACK)
//   WAIT_CNT_W       : width of the wait-state down-counter (WAIT_STATES <= 15)
//   UNMAPPED_DEFAULT : all-ones source for the default unmapped read value
package csram_sync_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  localparam int unsigned WAIT_CNT_W = 4;

  localparam int unsigned MAX_DATA_W = 64;
  localparam logic [MAX_DATA_W-1:0] UNMAPPED_DEFAULT = '1;

endpackage

// File: rtl/csram_sync_array.sv
// Single-port DEPTH x DATA_WIDTH storage, synchronous write, registered read.
// The read register only updates on re, so it holds the last read word while
// other writes go by. No reset on storage or read register (block-RAM style).
//   clk   : clock
//   we    : write enable, wdata -> mem[addr]
//   re    : read enable, mem[addr] -> rdata on the next edge
//   addr  : word address
//   wdata : write data
//   rdata : registered read data
module csram_sync_array #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 4096,
  parameter int unsigned ADDR_W     = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage write and registered read share the single address port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/csram_sync.sv
// Clocked req/ack program/data SRAM with configurable wait states and a
// sequential-write loader port for streaming program images in at run time.
//   clk, reset        : clock, asynchronous active-high reset
//   in_req            : CPU access request, held until out_ack
//   in_write_enable   : 1 = write, 0 = read (sampled at acceptance)
//   in_address        : word address (sampled at acceptance)
//   in_data           : write data (sampled at acceptance)
//   out_ack           : one-cycle completion pulse
//   out_data          : read data / write echo, held between acks
//   in_load_start     : clears the loader pointer and wrapped flag
//   in_load_valid     : loader word present
//   in_load_data      : loader word
//   out_load_ready    : loader may transfer this cycle (idle, no CPU request)
//   out_load_wrapped  : sticky, loader pointer wrapped past DEPTH-1
module csram_sync
  import csram_sync_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH     = 16,
  parameter int unsigned           ADDR_WIDTH     = 16,
  parameter int unsigned           DEPTH          = 4096,
  parameter int unsigned           WAIT_STATES    = 0,
  parameter logic [DATA_WIDTH-1:0] UNMAPPED_VALUE = UNMAPPED_DEFAULT[DATA_WIDTH-1:0]
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_req,
  input  logic                  in_write_enable,
  input  logic [ADDR_WIDTH-1:0] in_address,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_ack,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  in_load_start,
  input  logic                  in_load_valid,
  input  logic [DATA_WIDTH-1:0] in_load_data,
  output logic                  out_load_ready,
  output logic                  out_load_wrapped
);

  localparam int unsigned ARR_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e                  state_q, state_d;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    cpu_go;

  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    we_q;

  logic [ADDR_WIDTH-1:0]   cpu_addr;
  logic [DATA_WIDTH-1:0]   cpu_wdata;
  logic                    cpu_we;
  logic                    cpu_mapped;

  logic [ARR_AW-1:0]       ptr_q;
  logic [ARR_AW-1:0]       ptr_base;
  logic                    load_fire;
  logic                    load_wrap;

  logic                    use_array_q;
  logic [DATA_WIDTH-1:0]   hold_q;

  logic                    arr_we, arr_re;
  logic [ARR_AW-1:0]       arr_addr;
  logic [DATA_WIDTH-1:0]   arr_wdata, arr_rdata;

  // In IDLE the access is taken straight from the ports so a zero-wait
  // access can hit the array on its acceptance edge.
  assign cpu_addr   = (state_q == ST_IDLE) ? in_address      : addr_q;
  assign cpu_wdata  = (state_q == ST_IDLE) ? in_data         : wdata_q;
  assign cpu_we     = (state_q == ST_IDLE) ? in_write_enable : we_q;
  assign cpu_mapped = 64'(cpu_addr) < 64'(DEPTH);

  // Loader: start redirects this cycle's transfer to address 0.
  assign out_load_ready = (state_q == ST_IDLE) && !in_req;
  assign load_fire      = in_load_valid && out_load_ready;
  assign ptr_base       = in_load_start ? '0 : ptr_q;
  assign load_wrap      = load_fire && (ptr_base == ARR_AW'(DEPTH - 1));

  // Array port mux: CPU and loader never fire on the same edge.
  assign arr_we    = (cpu_go && cpu_we && cpu_mapped) || load_fire;
  assign arr_re    = cpu_go && !cpu_we && cpu_mapped;
  assign arr_addr  = cpu_go ? cpu_addr[ARR_AW-1:0] : ptr_base;
  assign arr_wdata = cpu_go ? cpu_wdata : in_load_data;

  // Mapped reads show the array's read register; everything else the hold reg.
  assign out_data = use_array_q ? arr_rdata : hold_q;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; cpu_go marks the edge that enters ACK and performs the access.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cpu_go  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_req) begin
          if (WAIT_STATES == 0) begin
            state_d = ST_ACK;
            cpu_go  = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_CNT_W'(WAIT_STATES - 1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_ACK;
          cpu_go  = 1'b1;
        end else begin
          cnt_d = cnt_q - WAIT_CNT_W'(1);
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latch, ack/result registers and loader pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q           <= '0;
      wdata_q          <= '0;
      we_q             <= 1'b0;
      out_ack          <= 1'b0;
      use_array_q      <= 1'b0;
      hold_q           <= UNMAPPED_VALUE;
      ptr_q            <= '0;
      out_load_wrapped <= 1'b0;
    end else begin
      if ((state_q == ST_IDLE) && in_req) begin
        addr_q  <= in_address;
        wdata_q <= in_data;
        we_q    <= in_write_enable;
      end

      out_ack <= cpu_go;
      if (cpu_go) begin
        if (cpu_we) begin
          use_array_q <= 1'b0;
          hold_q      <= cpu_wdata;
        end else if (cpu_mapped) begin
          use_array_q <= 1'b1;
        end else begin
          use_array_q <= 1'b0;
          hold_q      <= UNMAPPED_VALUE;
        end
      end

      if (load_fire) begin
        ptr_q <= load_wrap ? '0 : ptr_base + ARR_AW'(1);
      end else begin
        ptr_q <= ptr_base;
      end
      out_load_wrapped <= (in_load_start ? 1'b0 : out_load_wrapped) | load_wrap;
    end
  end

  csram_sync_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (ARR_AW)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .re    (arr_re),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

endmodule

// File: tb/tb_csram_sync.sv
// Bench for csram_sync: two instances (WAIT_STATES 0 and 3, DEPTH 4096)
// checked against a cycle-indexed behavioural model plus literal expectations.
module tb_csram_sync;

  localparam int unsigned DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rst    [2];
  logic        req    [2];
  logic        we     [2];
  logic [15:0] addr   [2];
  logic [15:0] wd     [2];
  logic        ack    [2];
  logic [15:0] odata  [2];
  logic        lstart [2];
  logic        lvalid [2];
  logic [15:0] ldata  [2];
  logic        lrdy   [2];
  logic        lwrap  [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  csram_sync #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset(rst[0]), .in_req(req[0]), .in_write_enable(we[0]),
    .in_address(addr[0]), .in_data(wd[0]), .out_ack(ack[0]), .out_data(odata[0]),
    .in_load_start(lstart[0]), .in_load_valid(lvalid[0]), .in_load_data(ldata[0]),
    .out_load_ready(lrdy[0]), .out_load_wrapped(lwrap[0])
  );

  csram_sync #(.DEPTH(DEPTH), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .reset(rst[1]), .in_req(req[1]), .in_write_enable(we[1]),
    .in_address(addr[1]), .in_data(wd[1]), .out_ack(ack[1]), .out_data(odata[1]),
    .in_load_start(lstart[1]), .in_load_valid(lvalid[1]), .in_load_data(ldata[1]),
    .out_load_ready(lrdy[1]), .out_load_wrapped(lwrap[1])
  );

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", nm, i, act, exp, $time);
    end
  endtask

  function automatic int ws_of(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  // Model: an access accepted at edge n completes (and acks) at edge n+WS and
  // the memory is idle again after edge n+WS+1.
  int          cyc = 0;
  bit          m_busy  [2];
  int          m_due   [2];
  bit          m_we    [2];
  logic [15:0] m_addr  [2];
  logic [15:0] m_wd    [2];
  bit          m_ack   [2];
  logic [15:0] m_data  [2];
  bit          m_known [2];
  int          m_ptr   [2];
  bit          m_wrap  [2];
  logic [15:0] mmem [int];

  always @(posedge clk) begin
    bit rdy;
    int key;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) begin
        m_busy[i] = 0; m_ack[i] = 0; m_data[i] = 16'hFFFF; m_known[i] = 1;
        m_ptr[i] = 0; m_wrap[i] = 0;
      end else begin
        rdy = !m_busy[i] && !req[i];
        m_ack[i] = 0;
        if (!m_busy[i] && req[i]) begin
          m_busy[i] = 1; m_we[i] = we[i]; m_addr[i] = addr[i]; m_wd[i] = wd[i];
          m_due[i] = cyc + ws_of(i);
        end else if (m_busy[i] && cyc == m_due[i] + 1) begin
          m_busy[i] = 0;
        end
        if (m_busy[i] && cyc == m_due[i]) begin
          m_ack[i] = 1;
          key = i * 65536 + int'(m_addr[i]);
          if (m_we[i]) begin
            m_data[i] = m_wd[i]; m_known[i] = 1;
            if (int'(m_addr[i]) < DEPTH) mmem[key] = m_wd[i];
          end else if (int'(m_addr[i]) >= DEPTH) begin
            m_data[i] = 16'hFFFF; m_known[i] = 1;
          end else if (mmem.exists(key)) begin
            m_data[i] = mmem[key]; m_known[i] = 1;
          end else begin
            m_known[i] = 0;
          end
        end
        if (lstart[i]) begin
          m_ptr[i] = 0; m_wrap[i] = 0;
        end
        if (lvalid[i] && rdy) begin
          mmem[i * 65536 + m_ptr[i]] = ldata[i];
          m_ptr[i]++;
          if (m_ptr[i] == DEPTH) begin
            m_ptr[i] = 0; m_wrap[i] = 1;
          end
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst[i]) begin
        chk("ack", i, 32'(ack[i]), 32'(m_ack[i]));
        chk("load_ready", i, 32'(lrdy[i]), 32'(!m_busy[i] && !req[i]));
        chk("load_wrapped", i, 32'(lwrap[i]), 32'(m_wrap[i]));
        if (m_known[i]) chk("out_data", i, 32'(odata[i]), 32'(m_data[i]));
      end
    end
  end

  task automatic access(input int i, input bit w, input logic [15:0] a, input logic [15:0] d,
                        input bit with_load, output logic [15:0] rd, output int lat,
                        output int rdy_seen);
    bit got;
    @(posedge clk); #1;
    req[i] = 1'b1; we[i] = w; addr[i] = a; wd[i] = d;
    if (with_load) begin
      lvalid[i] = 1'b1; ldata[i] = 16'h9999;
    end
    got = 0; lat = 0; rd = '0; rdy_seen = 0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (lrdy[i]) rdy_seen++;
      if (ack[i]) begin
        got = 1; lat = k; rd = odata[i];
      end
    end
    if (!got) chk("ack_timeout", i, 32'(0), 32'(1));
    @(posedge clk); #1;
    req[i] = 1'b0;
    if (with_load) begin
      @(posedge clk); #1;
      lvalid[i] = 1'b0;
    end
  endtask

  task automatic load_one(input int i, input logic [15:0] d, input bit start);
    @(posedge clk); #1;
    lvalid[i] = 1'b1; ldata[i] = d; lstart[i] = start;
    @(posedge clk); #1;
    lvalid[i] = 1'b0; lstart[i] = 1'b0;
  endtask

  initial begin
    logic [15:0] rd;
    int lat, rs, acks;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wd[i] = '0;
      lstart[i] = 1'b0; lvalid[i] = 1'b0; ldata[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0; rst[1] = 1'b0;

    @(negedge clk);
    chk("rst_data", 0, 32'(odata[0]), 32'h0000_FFFF);
    chk("rst_ack", 0, 32'(ack[0]), 32'(0));
    chk("rst_ready", 0, 32'(lrdy[0]), 32'(1));
    chk("rst_wrapped", 0, 32'(lwrap[0]), 32'(0));

    // Zero-wait instance: loader, read, unmapped handling.
    load_one(0, 16'h1234, 1'b1);
    load_one(0, 16'h5678, 1'b0);
    access(0, 1'b0, 16'h0001, 16'h0000, 1'b0, rd, lat, rs);
    chk("ws0_lat", 0, 32'(lat), 32'(1));
    chk("ws0_rd1", 0, 32'(rd), 32'h5678);
    access(0, 1'b0, 16'h2000, 16'h0000, 1'b0, rd, lat, rs);
    chk("unmapped_rd", 0, 32'(rd), 32'hFFFF);
    access(0, 1'b1, 16'h2000, 16'hAAAA, 1'b0, rd, lat, rs);
    chk("unmapped_wr_echo", 0, 32'(rd), 32'hAAAA);
    access(0, 1'b0, 16'h0000, 16'h0000, 1'b0, rd, lat, rs);
    chk("rd0_after_unmapped_wr", 0, 32'(rd), 32'h1234);

    // Three-wait instance: write then read-after-write.
    access(1, 1'b1, 16'h0010, 16'hBEEF, 1'b0, rd, lat, rs);
    chk("ws3_wr_lat", 1, 32'(lat), 32'(4));
    chk("ws3_wr_echo", 1, 32'(rd), 32'hBEEF);
    access(1, 1'b0, 16'h0010, 16'h0000, 1'b0, rd, lat, rs);
    chk("ws3_rd_lat", 1, 32'(lat), 32'(4));
    chk("ws3_rd", 1, 32'(rd), 32'hBEEF);

    // Reset while the access sits in WAIT: abandoned, contents kept.
    @(posedge clk); #1;
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 16'h0010;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst[1] = 1'b1; req[1] = 1'b0;
    @(negedge clk);
    chk("rst_wait_ack", 1, 32'(ack[1]), 32'(0));
    chk("rst_wait_data", 1, 32'(odata[1]), 32'hFFFF);
    @(posedge clk); #1;
    rst[1] = 1'b0;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack[1]) acks++;
    end
    chk("no_ack_after_rst", 1, 32'(acks), 32'(0));
    chk("lrdy_after_rst", 1, 32'(lrdy[1]), 32'(1));
    access(1, 1'b0, 16'h0010, 16'h0000, 1'b0, rd, lat, rs);
    chk("rd_after_rst", 1, 32'(rd), 32'hBEEF);

    // Loader wrap: DEPTH+1 words, last lands at address 0.
    @(posedge clk); #1;
    for (int k = 0; k <= int'(DEPTH); k++) begin
      lvalid[0] = 1'b1; ldata[0] = 16'(k) ^ 16'h5A5A; lstart[0] = (k == 0);
      @(posedge clk); #1;
    end
    lvalid[0] = 1'b0; lstart[0] = 1'b0;
    @(negedge clk);
    chk("wrapped_set", 0, 32'(lwrap[0]), 32'(1));
    access(0, 1'b0, 16'h0000, 16'h0000, 1'b0, rd, lat, rs);
    chk("wrap_last_word", 0, 32'(rd), 32'h4A5A);
    load_one(0, 16'h7777, 1'b0);
    access(0, 1'b0, 16'h0001, 16'h0000, 1'b0, rd, lat, rs);
    chk("ptr_after_wrap", 0, 32'(rd), 32'h7777);

    // CPU request wins over a simultaneous loader word.
    access(0, 1'b0, 16'h0001, 16'h0000, 1'b1, rd, lat, rs);
    chk("contention_ready", 0, 32'(rs), 32'(0));
    chk("contention_rd", 0, 32'(rd), 32'h7777);
    access(0, 1'b0, 16'h0002, 16'h0000, 1'b0, rd, lat, rs);
    chk("deferred_load", 0, 32'(rd), 32'h9999);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
